bv8_mul_pipe: RTL
=================

# bv8_mul_pipe

Pipelined, multi-lane GF(2^8) multiplier in the tower-field normal-basis representation GF(((2^2)^2)^2) used throughout the AES datapath. Each lane splits its operands into GF(2^4) halves and combines three GF(2^4) products and one scaled cross term, mirroring the GF(2^4)-over-GF(2^2) construction one level up. A valid/ready handshake with per-stage bubble collapsing lets it sit between the S-box inversion stages and the back-pressured round datapath.

## Interface
- LANES, default 1: number of independent GF(2^8) multipliers sharing one handshake; 1..16.
- PIPE, default 2: register stages, 1 or 2; latency equals PIPE.
- in_clock  input  1  clock, rising edge.
- in_reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block accepts a bundle this cycle.
- in_square  input  1  1: each lane computes a*a and ignores in_b.
- in_a  input  LANES x bv8_t  multiplicand per lane, normal-basis tower encoding.
- in_b  input  LANES x bv8_t  multiplier per lane.
- out_valid  output  1  product bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_c  output  LANES x bv8_t  product per lane.

## Operation
- Per lane: a_hi=a[7:4], a_lo=a[3:0], same for b (b replaced by a when in_square=1, sampled with the bundle).
- p_lo = a_lo*b_lo, p_hi = a_hi*b_hi, s = (a_hi^a_lo)*(b_hi^b_lo), all in GF(2^4).
- m = scale(s): multiplication by the GF(2^4) normal-basis constant LAMBDA from the shared package.
- c[3:0] = p_lo ^ m; c[7:4] = p_hi ^ m.
- Field identity is 8'hFF; zero is 8'h00. Result is bit-exact, independent of PIPE and of stall pattern.
- PIPE=2: stage 1 registers p_lo, p_hi, m per lane; stage 2 registers c. PIPE=1: single register after the final XOR.
- Each stage k holds valid_k. ready_k = !valid_k || ready_{k+1}; ready_{PIPE+1} = out_ready; in_ready = ready_1.
- Stage k loads when ready_k; valid_k <= valid_{k-1} (valid_0 = in_valid). Data registers load only when ready_k && valid_{k-1}; otherwise hold.
- out_valid = valid_PIPE; out_c = stage-PIPE data register.
- Bundle transfers occur on in_valid && in_ready (input) and out_valid && out_ready (output). Lanes never desynchronise.

## Timing
- Reset (asynchronous, any time, including mid-stream): all valid_k = 0, all data registers = 0 immediately; out_valid = 0, out_c = 0, in_ready = 1 while reset is high and the first cycle after. In-flight bundles are discarded.
- Latency: bundle accepted at edge t appears with out_valid=1 after edge t+PIPE-1 (visible in cycle t+PIPE) if no stall.
- Throughput: one bundle per cycle with out_ready held high.
- Stall: out_ready=0 with out_valid=1 holds out_c stable and out_valid high until accepted; upstream stage fills if empty (bubble collapse), then in_ready drops. PIPE=2 full-stall capacity is 2 bundles.
- Simultaneous output accept and input accept in a full pipeline: both occur in the same cycle, no bubble inserted.
- in_ready depends combinationally on out_ready (no registered skid); out_valid and out_c are register outputs only.
- in_a/in_b/in_square ignored when in_valid=0; no X propagation into registers on idle cycles.

## Structure
- Shared package: bv8_t, LAMBDA (GF(2^4) normal-basis scale constant), existing bv4_t/bv2_t.
- Sub-module bv8_mul_comb: one combinational lane, split into stage-1 (p_lo, p_hi, m) and final-XOR outputs for register insertion; instantiated LANES times via generate, built from the existing GF(2^4) multiplier and a new bv4_scl_l scaler.
- Top level owns only the valid/ready chain and pipeline registers.

## Test plan
- Identity/zero: LANES=4, PIPE=2, a={8'h00,8'h5A,8'hFF,8'hC3}, b=8'hFF all lanes -> out_c equals a two cycles later; b=8'h00 -> all 8'h00.
- Exhaustive: LANES=1, all 65536 (a,b) pairs back-to-back, out_ready=1 -> one result per cycle, matching a bit-level tower-field model; commutativity a*b==b*a checked.
- Square mode: in_square=1, in_b=random -> out_c == model(a,a); toggling in_square per bundle never leaks to neighbours.
- Back-pressure: stream 10 bundles, out_ready pattern 1,0,0,1,0,1,1,... -> in-order, no loss/duplication, out_c stable during stall, in_ready low only when both stages full.
- Reset mid-stream: assert in_reset asynchronously with 2 bundles in flight -> out_valid=0, out_c=0 immediately, no stale bundle after release.
- PIPE=1 vs PIPE=2 on identical random stimulus -> identical output sequences, latency 1 vs 2.

Source files
------------

// File: rtl/bv8_mul_pipe_pkg.sv
// Shared tower-field types and GF(2^2)/GF(2^4) arithmetic for the bv8 datapath.
// Normal bases: GF(2^2) over (W^2, W), GF(2^4) over (Z^4, Z) with Z^2+Z+N=0,
// GF(2^8) over (Y^16, Y) with Y^2+Y+LAMBDA=0. The upper field of each level sits
// in the upper bits, so the field identity is all ones at every level.
package bv8_mul_pipe_pkg;

    typedef logic [1:0] bv2_t;
    typedef logic [3:0] bv4_t;
    typedef logic [7:0] bv8_t;

    // Stage-1 results of one lane: the two half products and the scaled cross term.
    typedef struct packed {
        bv4_t p_hi;
        bv4_t p_lo;
        bv4_t m;
    } bv8_s1_t;

    // N = W^2 in GF(2^2); LAMBDA = N^2 * Z = W * Z in GF(2^4).
    localparam bv2_t N_CONST  = 2'b10;
    localparam bv4_t LAMBDA   = 4'h1;
    localparam bv8_t BV8_ONE  = 8'hFF;
    localparam bv8_t BV8_ZERO = 8'h00;

    // GF(2^2) normal-basis product.
    function automatic bv2_t bv2_mul(input bv2_t a, input bv2_t b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    // Multiply a GF(2^2) element by N = W^2.
    function automatic bv2_t bv2_scl_n(input bv2_t a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    // GF(2^4) normal-basis product built from GF(2^2) products.
    function automatic bv4_t bv4_mul(input bv4_t a, input bv4_t b);
        bv2_t e;
        e = bv2_scl_n(bv2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {bv2_mul(a[3:2], b[3:2]) ^ e, bv2_mul(a[1:0], b[1:0]) ^ e};
    endfunction

    // Multiply a GF(2^4) element by LAMBDA = W*Z. With Z*Z^4 = N and W*N = 1
    // the product collapses to hi = x1 ^ x0, lo = x1 ^ N*x0.
    function automatic bv4_t bv4_scl_l(input bv4_t x);
        return {x[3:2] ^ x[1:0], x[3:2] ^ bv2_scl_n(x[1:0])};
    endfunction

endpackage

// File: rtl/bv8_mul_pipe_comb.sv
// One combinational GF(2^8) tower-field lane, split at the stage-1 boundary so the
// parent can place a register between the products and the final XOR.
module bv8_mul_comb
    import bv8_mul_pipe_pkg::*;
(
    input  logic    square_i,
    input  bv8_t    a_i,
    input  bv8_t    b_i,
    output bv8_s1_t s1_o,
    input  bv8_s1_t s1_i,
    output bv8_t    c_o
);

    bv8_t b_eff;
    bv4_t s_cross;

    // Half products and scaled cross term; squaring reuses a as the multiplier.
    always_comb begin
        b_eff     = square_i ? a_i : b_i;
        s_cross   = bv4_mul(a_i[7:4] ^ a_i[3:0], b_eff[7:4] ^ b_eff[3:0]);
        s1_o      = '0;
        s1_o.p_hi = bv4_mul(a_i[7:4], b_eff[7:4]);
        s1_o.p_lo = bv4_mul(a_i[3:0], b_eff[3:0]);
        s1_o.m    = bv4_scl_l(s_cross);
    end

    // Fold the scaled cross term into both halves.
    always_comb begin
        c_o = {s1_i.p_hi ^ s1_i.m, s1_i.p_lo ^ s1_i.m};
    end

endmodule

// File: rtl/bv8_mul_pipe.sv
// Multi-lane pipelined GF(2^8) tower-field multiplier with a valid/ready chain.
// Each register stage refills whenever it is empty or its successor drains, so
// bubbles collapse and a full pipeline still accepts and emits in one cycle.
module bv8_mul_pipe
    import bv8_mul_pipe_pkg::*;
#(
    parameter int unsigned LANES = 1,
    parameter int unsigned PIPE  = 2
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_square,
    input  bv8_t [LANES-1:0]   in_a,
    input  bv8_t [LANES-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output bv8_t [LANES-1:0]   out_c
);

    bv8_s1_t [LANES-1:0] s1_comb;
    bv8_s1_t [LANES-1:0] s1_fin;
    bv8_t    [LANES-1:0] c_comb;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bv8_mul_comb u_lane (
            .square_i (in_square),
            .a_i      (in_a[l]),
            .b_i      (in_b[l]),
            .s1_o     (s1_comb[l]),
            .s1_i     (s1_fin[l]),
            .c_o      (c_comb[l])
        );
    end

    if (PIPE == 2) begin : g_pipe2
        logic                v1_q, v1_d, v2_q, v2_d;
        logic                rdy1, rdy2;
        bv8_s1_t [LANES-1:0] s1_q, s1_d;
        bv8_t    [LANES-1:0] c_q, c_d;

        // Ready chain and next-state for both stages; data moves only with a valid bundle.
        always_comb begin
            rdy2 = !v2_q || out_ready;
            rdy1 = !v1_q || rdy2;
            v1_d = rdy1 ? in_valid : v1_q;
            v2_d = rdy2 ? v1_q : v2_q;
            s1_d = (rdy1 && in_valid) ? s1_comb : s1_q;
            c_d  = (rdy2 && v1_q) ? c_comb : c_q;
        end

        // Stage registers, cleared asynchronously so in-flight bundles are dropped.
        always_ff @(posedge in_clock or posedge in_reset) begin
            if (in_reset) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
                s1_q <= '0;
                c_q  <= '0;
            end else begin
                v1_q <= v1_d;
                v2_q <= v2_d;
                s1_q <= s1_d;
                c_q  <= c_d;
            end
        end

        // Port mapping of the two-stage pipeline.
        always_comb begin
            s1_fin    = s1_q;
            in_ready  = rdy1;
            out_valid = v2_q;
            out_c     = c_q;
        end
    end else begin : g_pipe1
        logic               v1_q, v1_d;
        logic               rdy1;
        bv8_t [LANES-1:0]   c_q, c_d;

        // Single stage after the final XOR.
        always_comb begin
            s1_fin = s1_comb;
            rdy1   = !v1_q || out_ready;
            v1_d   = rdy1 ? in_valid : v1_q;
            c_d    = (rdy1 && in_valid) ? c_comb : c_q;
        end

        // Output register, cleared asynchronously.
        always_ff @(posedge in_clock or posedge in_reset) begin
            if (in_reset) begin
                v1_q <= 1'b0;
                c_q  <= '0;
            end else begin
                v1_q <= v1_d;
                c_q  <= c_d;
            end
        end

        // Port mapping of the single-stage pipeline.
        always_comb begin
            in_ready  = rdy1;
            out_valid = v1_q;
            out_c     = c_q;
        end
    end

endmodule
